// File: rtl/api_reg_responder.sv
// Register-file responder behind the SciEngines API core: pops request packets,
// executes register writes/reads and returns read responses to the requester.
`timescale 1ns/1ps
module api_reg_responder #(
    parameter int unsigned           LENGTH_ADDR_SLOT = 4,
    parameter int unsigned           LENGTH_ADDR_FPGA = 4,
    parameter int unsigned           LENGTH_ADDR_REG  = 8,
    parameter int unsigned           LENGTH_CMD       = 8,
    parameter int unsigned           LENGTH_DATA      = 64,
    parameter int unsigned           NUM_REGS         = 16,
    parameter logic [LENGTH_CMD-1:0] CMD_WRITE        = 8'h01,
    parameter logic [LENGTH_CMD-1:0] CMD_READ         = 8'h02,
    parameter logic [LENGTH_CMD-1:0] CMD_RESP         = 8'h82
) (
    input  logic                        api_clk_in,
    input  logic                        api_rst_n_in,
    input  logic                        api_i_empty_in,
    output logic                        api_i_rd_en_out,
    input  logic [LENGTH_ADDR_SLOT-1:0] api_i_src_slot_in,
    input  logic [LENGTH_ADDR_FPGA-1:0] api_i_src_fpga_in,
    input  logic [LENGTH_ADDR_REG-1:0]  api_i_src_reg_in,
    input  logic [LENGTH_CMD-1:0]       api_i_src_cmd_in,
    input  logic [LENGTH_ADDR_REG-1:0]  api_i_tgt_reg_in,
    input  logic [LENGTH_CMD-1:0]       api_i_tgt_cmd_in,
    input  logic [LENGTH_DATA-1:0]      api_i_data_in,
    input  logic                        api_o_rfd_in,
    output logic                        api_o_wr_en_out,
    output logic [LENGTH_ADDR_SLOT-1:0] api_o_tgt_slot_out,
    output logic [LENGTH_ADDR_FPGA-1:0] api_o_tgt_fpga_out,
    output logic [LENGTH_ADDR_REG-1:0]  api_o_tgt_reg_out,
    output logic [LENGTH_CMD-1:0]       api_o_tgt_cmd_out,
    output logic [LENGTH_ADDR_REG-1:0]  api_o_src_reg_out,
    output logic [LENGTH_CMD-1:0]       api_o_src_cmd_out,
    output logic [LENGTH_DATA-1:0]      api_o_data_out,
    input  logic [$clog2(NUM_REGS)-1:0] usr_rd_addr_in,
    output logic [LENGTH_DATA-1:0]      usr_rd_data_out,
    output logic                        usr_wr_stb_out,
    output logic [$clog2(NUM_REGS)-1:0] usr_wr_idx_out,
    output logic [15:0]                 err_cnt_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned ERR_W = 16;

    typedef struct packed {
        logic [LENGTH_ADDR_SLOT-1:0] src_slot;
        logic [LENGTH_ADDR_FPGA-1:0] src_fpga;
        logic [LENGTH_ADDR_REG-1:0]  src_reg;
        logic [LENGTH_CMD-1:0]       src_cmd;
        logic [LENGTH_ADDR_REG-1:0]  tgt_reg;
        logic [LENGTH_CMD-1:0]       tgt_cmd;
        logic [LENGTH_DATA-1:0]      data;
    } req_t;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, RESP} state_t;

    state_t                 state_q;
    state_t                 state_d;
    req_t                   req_q;
    logic [LENGTH_DATA-1:0] regfile_q [NUM_REGS];
    logic [ERR_W-1:0]       err_cnt_q;

    logic                   latch_req;
    logic                   load_resp;
    logic                   count_err;
    logic [IDX_W-1:0]       req_idx;
    logic                   idx_ok;
    logic                   is_write;
    logic                   is_read;

    // Range check on the full register field, then decode with the low bits.
    assign req_idx  = req_q.tgt_reg[IDX_W-1:0];
    assign idx_ok   = 32'(req_q.tgt_reg) < NUM_REGS;
    assign is_write = req_q.tgt_cmd == CMD_WRITE;
    assign is_read  = req_q.tgt_cmd == CMD_READ;

    assign usr_rd_data_out = regfile_q[usr_rd_addr_in];
    assign err_cnt_out     = err_cnt_q;

    always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
        if (!api_rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!api_i_empty_in) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = is_read ? RESP : IDLE;
            RESP:    if (api_o_rfd_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes; the pop is gated by reset so nothing leaks out while reset is held.
    always_comb begin
        api_i_rd_en_out = 1'b0;
        api_o_wr_en_out = 1'b0;
        usr_wr_stb_out  = 1'b0;
        latch_req       = 1'b0;
        load_resp       = 1'b0;
        count_err       = 1'b0;
        case (state_q)
            IDLE:  api_i_rd_en_out = !api_i_empty_in && api_rst_n_in;
            FETCH: latch_req = 1'b1;
            EXEC: begin
                if (is_write && idx_ok) begin
                    usr_wr_stb_out = 1'b1;
                end else if (is_read) begin
                    load_resp = 1'b1;
                    count_err = !idx_ok;
                end else begin
                    count_err = 1'b1;
                end
            end
            RESP:    api_o_wr_en_out = api_o_rfd_in;
            default: ;
        endcase
    end

    always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
        if (!api_rst_n_in) begin
            req_q              <= '0;
            for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= '0;
            api_o_tgt_slot_out <= '0;
            api_o_tgt_fpga_out <= '0;
            api_o_tgt_reg_out  <= '0;
            api_o_tgt_cmd_out  <= '0;
            api_o_src_reg_out  <= '0;
            api_o_src_cmd_out  <= '0;
            api_o_data_out     <= '0;
            usr_wr_idx_out     <= '0;
            err_cnt_q          <= '0;
        end else begin
            if (latch_req) begin
                req_q.src_slot <= api_i_src_slot_in;
                req_q.src_fpga <= api_i_src_fpga_in;
                req_q.src_reg  <= api_i_src_reg_in;
                req_q.src_cmd  <= api_i_src_cmd_in;
                req_q.tgt_reg  <= api_i_tgt_reg_in;
                req_q.tgt_cmd  <= api_i_tgt_cmd_in;
                req_q.data     <= api_i_data_in;
            end
            if (usr_wr_stb_out) begin
                regfile_q[req_idx] <= req_q.data;
                usr_wr_idx_out     <= req_idx;
            end
            // Response is addressed back to the requester's return register/command.
            if (load_resp) begin
                api_o_tgt_slot_out <= req_q.src_slot;
                api_o_tgt_fpga_out <= req_q.src_fpga;
                api_o_tgt_reg_out  <= req_q.src_reg;
                api_o_tgt_cmd_out  <= req_q.src_cmd;
                api_o_src_reg_out  <= req_q.tgt_reg;
                api_o_src_cmd_out  <= CMD_RESP;
                api_o_data_out     <= idx_ok ? regfile_q[req_idx] : '0;
            end
            if (count_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_api_reg_responder.sv
// Directed + randomized bench for api_reg_responder with a packet-level reference
// model (register array, expected-response and expected-write queues).
`timescale 1ns/1ps
module tb_api_reg_responder;

    localparam int unsigned NREG   = 16;
    localparam logic [7:0]  C_WR   = 8'h01;
    localparam logic [7:0]  C_RD   = 8'h02;
    localparam logic [7:0]  C_RESP = 8'h82;

    typedef struct packed {
        logic [3:0]  slot;
        logic [3:0]  fpga;
        logic [7:0]  sreg;
        logic [7:0]  scmd;
        logic [7:0]  treg;
        logic [7:0]  tcmd;
        logic [63:0] data;
    } pkt_t;

    typedef struct packed {
        logic [3:0]  tslot;
        logic [3:0]  tfpga;
        logic [7:0]  treg;
        logic [7:0]  tcmd;
        logic [7:0]  sreg;
        logic [7:0]  scmd;
        logic [63:0] data;
    } rsp_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        empty = 1'b1;
    logic [3:0]  i_slot = '0;
    logic [3:0]  i_fpga = '0;
    logic [7:0]  i_sreg = '0;
    logic [7:0]  i_scmd = '0;
    logic [7:0]  i_treg = '0;
    logic [7:0]  i_tcmd = '0;
    logic [63:0] i_data = '0;
    logic        rfd = 1'b1;
    logic [3:0]  rd_addr = '0;

    logic        rd_en, wr_en, wr_stb;
    logic [3:0]  o_tslot, o_tfpga, wr_idx;
    logic [7:0]  o_treg, o_tcmd, o_sreg, o_scmd;
    logic [63:0] o_data, rd_data;
    logic [15:0] err_cnt;
    logic [39:0] o_hdr;

    assign o_hdr = {o_tslot, o_tfpga, o_treg, o_tcmd, o_sreg, o_scmd};

    always #5 clk = ~clk;

    api_reg_responder dut (
        .api_clk_in         (clk),
        .api_rst_n_in       (rst_n),
        .api_i_empty_in     (empty),
        .api_i_rd_en_out    (rd_en),
        .api_i_src_slot_in  (i_slot),
        .api_i_src_fpga_in  (i_fpga),
        .api_i_src_reg_in   (i_sreg),
        .api_i_src_cmd_in   (i_scmd),
        .api_i_tgt_reg_in   (i_treg),
        .api_i_tgt_cmd_in   (i_tcmd),
        .api_i_data_in      (i_data),
        .api_o_rfd_in       (rfd),
        .api_o_wr_en_out    (wr_en),
        .api_o_tgt_slot_out (o_tslot),
        .api_o_tgt_fpga_out (o_tfpga),
        .api_o_tgt_reg_out  (o_treg),
        .api_o_tgt_cmd_out  (o_tcmd),
        .api_o_src_reg_out  (o_sreg),
        .api_o_src_cmd_out  (o_scmd),
        .api_o_data_out     (o_data),
        .usr_rd_addr_in     (rd_addr),
        .usr_rd_data_out    (rd_data),
        .usr_wr_stb_out     (wr_stb),
        .usr_wr_idx_out     (wr_idx),
        .err_cnt_out        (err_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          stb_cnt = 0;
    int          last_rd = -1;
    logic        spacing_on = 1'b0;
    logic        stall_on = 1'b0;
    logic        rand_rfd = 1'b0;

    logic [63:0] mregs [NREG];
    int unsigned merr = 0;
    pkt_t        fifo_q [$];
    rsp_t        exp_q [$];
    wr_t         exp_wr_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = '0;
        merr = 0;
        exp_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic bump_err();
        if (merr < 32'hFFFF) merr++;
    endtask

    // Queue a packet into the FIFO and apply its architectural effect to the model.
    task automatic push(input logic [3:0] slot, input logic [3:0] fpga, input logic [7:0] sreg,
                        input logic [7:0] scmd, input logic [7:0] treg, input logic [7:0] tcmd,
                        input logic [63:0] data);
        pkt_t p;
        rsp_t r;
        wr_t  w;
        logic in_range;
        p = '{slot, fpga, sreg, scmd, treg, tcmd, data};
        fifo_q.push_back(p);
        in_range = 32'(treg) < NREG;
        if (tcmd == C_WR && in_range) begin
            mregs[treg[3:0]] = data;
            w.idx = treg[3:0];
            w.data = data;
            exp_wr_q.push_back(w);
        end else if (tcmd == C_RD) begin
            r = '{slot, fpga, sreg, scmd, treg, C_RESP, (in_range ? mregs[treg[3:0]] : 64'd0)};
            if (!in_range) bump_err();
            exp_q.push_back(r);
        end else begin
            bump_err();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rfd) rfd = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int   n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = (fifo_q.size() != 0) || (exp_q.size() != 0) || (exp_wr_q.size() != 0) || !empty;
        end
        repeat (6) step();
        chk("drain_idle", 64'(busy), 64'd0);
    endtask

    // Non-FWFT FIFO: data appears the cycle after a pop, garbage otherwise.
    always begin
        pkt_t cur;
        logic pop_seen;
        @(negedge clk);
        pop_seen = rd_en;
        @(posedge clk);
        #1;
        if (pop_seen && fifo_q.size() != 0) begin
            cur = fifo_q.pop_front();
            i_slot = cur.slot;
            i_fpga = cur.fpga;
            i_sreg = cur.sreg;
            i_scmd = cur.scmd;
            i_treg = cur.treg;
            i_tcmd = cur.tcmd;
            i_data = cur.data;
        end else begin
            i_slot = 4'($urandom);
            i_fpga = 4'($urandom);
            i_sreg = 8'($urandom);
            i_scmd = 8'($urandom);
            i_treg = 8'($urandom);
            i_tcmd = 8'($urandom);
            i_data = {$urandom, $urandom};
        end
        empty = (fifo_q.size() == 0);
    end

    // Output monitor: pops, pop spacing, responses against the model.
    always @(negedge clk) begin
        rsp_t r;
        cycle++;
        if (rst_n) begin
            if (rd_en) begin
                rd_cnt++;
                chk("pop_when_empty", 64'(empty), 64'd0);
                if (spacing_on) begin
                    if (last_rd >= 0) chk("rd_en_spacing", 64'(cycle - last_rd), 64'd3);
                    last_rd = cycle;
                end
            end
            if (wr_en) begin
                wr_cnt++;
                chk("wr_en_needs_rfd", 64'(rfd), 64'd1);
                if (stall_on) begin
                    chk("wr_en_during_stall", 64'(wr_en), 64'd0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(wr_en), 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_tgt_slot", 64'(o_tslot), 64'(r.tslot));
                    chk("resp_tgt_fpga", 64'(o_tfpga), 64'(r.tfpga));
                    chk("resp_tgt_reg", 64'(o_treg), 64'(r.treg));
                    chk("resp_tgt_cmd", 64'(o_tcmd), 64'(r.tcmd));
                    chk("resp_src_reg", 64'(o_sreg), 64'(r.sreg));
                    chk("resp_src_cmd", 64'(o_scmd), 64'(r.scmd));
                    chk("resp_data", o_data, r.data);
                end
            end
        end
    end

    // Write strobe monitor: index and user read-back one cycle after each strobe.
    always @(negedge clk) begin
        wr_t  pend;
        logic have;
        have = 1'b0;
        if (rst_n && wr_stb) begin
            stb_cnt++;
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wr_stb", 64'(wr_stb), 64'd0);
            end else begin
                pend = exp_wr_q.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            @(negedge clk);
            chk("usr_wr_idx", 64'(wr_idx), 64'(pend.idx));
            rd_addr = pend.idx;
            #1;
            chk("usr_rd_data", rd_data, pend.data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          rd0;
        int          w0;
        logic [39:0] snap_hdr;
        logic [63:0] snap_data;
        logic [7:0]  treg;
        logic [7:0]  tcmd;
        int unsigned kind;

        model_reset();
        rst_n = 1'b0;
        rfd = 1'b1;
        repeat (2) step();

        // Reset values while the FIFO already holds a packet
        push(4'd0, 4'd0, 8'h00, 8'h00, 8'd3, C_WR, 64'hDEAD_BEEF_0123_4567);
        repeat (3) step();
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_stb", 64'(wr_stb), 64'd0);
        chk("rst_wr_idx", 64'(wr_idx), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_o_hdr", 64'(o_hdr), 64'd0);
        chk("rst_o_data", o_data, 64'd0);
        chk("rst_usr_rd_data", rd_data, 64'd0);
        rst_n = 1'b1;

        // Write idx 3 then read it back from slot 2 / fpga 5
        push(4'd2, 4'd5, 8'h10, 8'h33, 8'd3, C_RD, 64'h0);
        drain(200);
        chk("t1_resp_count", 64'(wr_cnt), 64'd1);
        chk("t1_stb_count", 64'(stb_cnt), 64'd1);
        chk("t1_wr_idx", 64'(wr_idx), 64'd3);
        chk("t1_tgt_slot", 64'(o_tslot), 64'd2);
        chk("t1_tgt_fpga", 64'(o_tfpga), 64'd5);
        chk("t1_tgt_reg", 64'(o_treg), 64'h10);
        chk("t1_tgt_cmd", 64'(o_tcmd), 64'h33);
        chk("t1_src_reg", 64'(o_sreg), 64'd3);
        chk("t1_src_cmd", 64'(o_scmd), 64'h82);
        chk("t1_data", o_data, 64'hDEAD_BEEF_0123_4567);

        // Read idx 7 with the output port stalled for 20 cycles
        rfd = 1'b0;
        rd0 = rd_cnt;
        w0 = wr_cnt;
        push(4'd1, 4'd3, 8'h44, 8'h55, 8'd7, C_RD, 64'h0);
        push(4'd0, 4'd0, 8'h00, 8'h00, 8'd9, C_WR, 64'h0123_4567_89AB_CDEF);
        repeat (6) step();
        stall_on = 1'b1;
        snap_hdr = o_hdr;
        snap_data = o_data;
        chk("stall_src_reg", 64'(o_sreg), 64'd7);
        repeat (20) begin
            step();
            chk("stall_o_hdr", 64'(o_hdr), 64'(snap_hdr));
            chk("stall_o_data", o_data, snap_data);
        end
        chk("stall_pops", 64'(rd_cnt - rd0), 64'd1);
        stall_on = 1'b0;
        rfd = 1'b1;
        #1;
        chk("stall_release_wr_en", 64'(wr_en), 64'd1);
        drain(200);
        chk("stall_resp_count", 64'(wr_cnt - w0), 64'd1);

        // Eight back-to-back writes with the FIFO never empty
        rd0 = rd_cnt;
        w0 = wr_cnt;
        last_rd = -1;
        spacing_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom_range(0, 15)), C_WR, {$urandom, $urandom});
        end
        drain(200);
        spacing_on = 1'b0;
        chk("b2b_pops", 64'(rd_cnt - rd0), 64'd8);
        chk("b2b_no_resp", 64'(wr_cnt - w0), 64'd0);

        // Bad opcode, out-of-range write, out-of-range read
        w0 = wr_cnt;
        push(4'd1, 4'd1, 8'h01, 8'h01, 8'd5, 8'h7F, 64'h1111);
        push(4'd1, 4'd1, 8'h01, 8'h01, 8'd20, C_WR, 64'h2222);
        push(4'd6, 4'd7, 8'h21, 8'h22, 8'd20, C_RD, 64'h3333);
        drain(200);
        chk("err_cnt_3", 64'(err_cnt), 64'd3);
        chk("err_resp_count", 64'(wr_cnt - w0), 64'd1);
        chk("err_resp_data", o_data, 64'd0);

        // Randomized traffic with a randomly toggling output-ready
        rand_rfd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            treg = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(16, 255));
            tcmd = (kind < 4) ? C_WR : (kind < 8) ? C_RD : 8'($urandom_range(3, 255));
            push(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), treg, tcmd, {$urandom, $urandom});
            repeat ($urandom_range(0, 4)) step();
        end
        drain(3000);
        rand_rfd = 1'b0;
        rfd = 1'b1;
        chk("rand_err_cnt", 64'(err_cnt), 64'(merr));

        // Reset asserted while a response is waiting in RESP
        rfd = 1'b0;
        push(4'd3, 4'd1, 8'h12, 8'h34, 8'd3, C_RD, 64'h0);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("rstm_wr_en", 64'(wr_en), 64'd0);
        chk("rstm_rd_en", 64'(rd_en), 64'd0);
        chk("rstm_o_hdr", 64'(o_hdr), 64'd0);
        chk("rstm_o_data", o_data, 64'd0);
        chk("rstm_err_cnt", 64'(err_cnt), 64'd0);
        chk("rstm_wr_idx", 64'(wr_idx), 64'd0);
        chk("rstm_usr_rd_data", rd_data, 64'd0);
        rfd = 1'b1;
        #1;
        chk("rstm_wr_en_rfd", 64'(wr_en), 64'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        w0 = wr_cnt;
        push(4'd3, 4'd1, 8'h12, 8'h34, 8'd3, C_RD, 64'h0);
        drain(200);
        chk("post_reset_resp_count", 64'(wr_cnt - w0), 64'd1);
        chk("post_reset_read", o_data, 64'd0);

        // Error counter saturation
        step();
        force dut.err_cnt_q = 16'hFFFE;
        step();
        release dut.err_cnt_q;
        merr = 32'hFFFE;
        step();
        chk("err_forced", 64'(err_cnt), 64'hFFFE);
        push(4'd0, 4'd0, 8'h00, 8'h00, 8'd1, 8'h7F, 64'h0);
        drain(200);
        chk("err_cnt_ffff", 64'(err_cnt), 64'hFFFF);
        push(4'd0, 4'd0, 8'h00, 8'h00, 8'd200, C_WR, 64'h5);
        push(4'd2, 4'd2, 8'h07, 8'h08, 8'd99, C_RD, 64'h6);
        push(4'd0, 4'd0, 8'h00, 8'h00, 8'd2, 8'h00, 64'h7);
        drain(200);
        chk("err_cnt_sat", 64'(err_cnt), 64'(merr));
        chk("err_cnt_sat_const", 64'(err_cnt), 64'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
